// File: rtl/coproc_pkg.sv
// Shared types for the coprocessor job controller: algorithm codes, FSM states
// and error codes reported to the host.
package coproc_pkg;

  localparam int TIMER_W = 20;

  typedef enum logic [1:0] {
    ALG_NN = 2'd0,
    ALG_PR = 2'd1,
    ALG_DC = 2'd2,
    ALG_BA = 2'd3
  } alg_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_FIN,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_UNSUPPORTED = 2'd1,
    ERR_TIMEOUT     = 2'd2,
    ERR_ABORTED     = 2'd3
  } err_e;

endpackage

// File: rtl/job_timer.sv
// Loadable up/down counter with a terminal-count compare; used both for the
// hung-engine timeout (counting up) and the write-drain window (counting down).
module job_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (up) begin
      count <= count + 1'b1;
    end else if (down) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == tc_val);

endmodule

// File: rtl/coproc_controller.sv
// Job sequencer for the resize engine bank: latches a command, releases the
// engine from reset, gates frame-buffer writes, and reports done/error.
module coproc_controller
  import coproc_pkg::*;
#(
  parameter logic [3:0]         ALG_MASK       = 4'b0001,
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 20'd200000,
  parameter int                 DRAIN_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] algorithm,
  input  logic       eng_done,
  output logic       eng_reset,
  output logic [1:0] alg_sel,
  output logic       wr_en,
  output logic       buf_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  state_e state, state_nxt;
  err_e   err_q, err_nxt;
  alg_e   alg_q;
  logic   tmo_tc, drn_tc;
  logic   engine_active_nxt;

  assign alg_sel  = alg_q;
  assign err_code = err_q;

  job_timer #(.WIDTH(TIMER_W)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_IDLE && start),
    .load_val ('0),
    .up       (state == ST_RUN),
    .down     (1'b0),
    .tc_val   (TIMEOUT_CYCLES - 1'b1),
    .tc       (tmo_tc)
  );

  job_timer #(.WIDTH(TIMER_W)) u_drain (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_RUN && eng_done),
    .load_val (TIMER_W'(DRAIN_CYCLES)),
    .up       (1'b0),
    .down     (state == ST_DRAIN),
    .tc_val   (TIMER_W'(1)),
    .tc       (drn_tc)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_NONE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (ALG_MASK[algorithm]) begin
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_ERR;
            err_nxt   = ERR_UNSUPPORTED;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_ABORTED;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort beats done, and done beats a coincident timeout.
        if (abort) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_ABORTED;
        end else if (eng_done) begin
          state_nxt = (DRAIN_CYCLES == 0) ? ST_FIN : ST_DRAIN;
        end else if (tmo_tc) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nxt = ST_ERR;
          err_nxt   = ERR_ABORTED;
        end else if (drn_tc) begin
          state_nxt = ST_FIN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign engine_active_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);

  // Outputs are decoded from the next state so each one is a plain flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      eng_reset <= 1'b0;
      alg_q     <= ALG_NN;
      wr_en     <= 1'b0;
      buf_sel   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != ST_IDLE);
      done      <= (state_nxt == ST_FIN);
      wr_en     <= engine_active_nxt;
      eng_reset <= engine_active_nxt;
      if (state == ST_IDLE && start) begin
        alg_q <= alg_e'(algorithm);
        error <= (state_nxt == ST_ERR);
        err_q <= err_nxt;
      end else if (state_nxt == ST_ERR) begin
        error <= 1'b1;
        err_q <= err_nxt;
      end
      if (state_nxt == ST_FIN) begin
        buf_sel <= ~buf_sel;
      end
    end
  end

endmodule

// File: doc/coproc_controller.md
Name: coproc_controller

Overview:
- Sequences the image-processing engine bank for one resize job per command: latches the command, releases the engine from reset, gates frame-buffer writes, waits for the engine's done, then reports completion.
- Sits between the host command interface and the algorithm engines: nearest neighbour, pixel replication, decimation, block averaging.
- Also flips the display/work frame-buffer select after each successful job, and guards against unsupported algorithms and hung engines.

Parameters:
- ALG_MASK, 4'b0001: bit i = 1 means algorithm code i is implemented; default is NN only.
- TIMEOUT_CYCLES, 20'd200000: RUN cycles allowed before a job is declared hung.
- DRAIN_CYCLES, 2: cycles WR_EN stays high after ENG_DONE, to flush the final pixel write.

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- START  in  1  one-cycle command strobe
- ABORT  in  1  cancels the current job; priority over all other inputs
- ALGORITHM  in  2  0=NN 1=PR 2=DC 3=BA; sampled only on an accepted START
- ENG_DONE  in  1  done flag from the selected engine
- ENG_RESET  out  1  active-low reset to the engine bank
- ALG_SEL  out  2  latched algorithm, drives the engine mux select
- WR_EN  out  1  frame-buffer write enable
- BUF_SEL  out  1  work buffer index; display buffer is ~BUF_SEL
- BUSY  out  1  high from an accepted START until the job ends
- DONE  out  1  one-cycle pulse on successful completion
- ERROR  out  1  sticky error flag
- ERR_CODE  out  2  0=none 1=unsupported algorithm 2=timeout 3=aborted

Behaviour:
- Reset values (RESET low, asynchronous): state IDLE, ENG_RESET=0, ALG_SEL=0, WR_EN=0, BUF_SEL=0, BUSY=0, DONE=0, ERROR=0, ERR_CODE=0, counters=0.
- All outputs are registered.
- IDLE:
  - ENG_RESET=0 (engine held in reset), WR_EN=0.
  - START=1 → latch ALGORITHM into ALG_SEL, BUSY=1, clear ERROR/ERR_CODE.
  - If ALG_MASK[ALGORITHM]=1 → LOAD; otherwise → ERR with ERR_CODE=1.
- LOAD (exactly 1 cycle):
  - ENG_RESET stays 0 so the engine sees a clean reset with ALG_SEL already stable.
  - Next state RUN; ENG_RESET=1 and WR_EN=1 from the first RUN cycle.
- RUN:
  - Timeout counter increments every cycle.
  - ENG_DONE=1 → DRAIN and load the drain counter with DRAIN_CYCLES.
  - Counter reaches TIMEOUT_CYCLES-1 without ENG_DONE → ERR, ERR_CODE=2.
  - ENG_DONE and timeout in the same cycle: ENG_DONE wins.
- DRAIN:
  - WR_EN stays 1 while the drain counter decrements.
  - Counter reaches 1 → FIN.
  - If DRAIN_CYCLES=0, go straight from RUN to FIN.
- FIN (1 cycle):
  - DONE=1, WR_EN=0, ENG_RESET=0, BUF_SEL toggles.
  - Next state IDLE; BUSY drops on that same transition.
- ERR (1 cycle):
  - ERROR=1 (sticky until the next accepted START), WR_EN=0, ENG_RESET=0, BUF_SEL unchanged.
  - Next state IDLE, BUSY=0. DONE is never pulsed on error.
- ABORT:
  - In LOAD/RUN/DRAIN → ERR with ERR_CODE=3 on the next edge; this takes precedence over ENG_DONE in the same cycle.
  - In IDLE/FIN/ERR: ignored.
- START while BUSY=1 is ignored. ALG_SEL never changes mid-job.
- START arriving in the FIN or ERR cycle is ignored; the host retries once BUSY=0.
- ENG_DONE is ignored outside RUN, including a stale high from the previous job.
- Timeout counter width is 20 bits; it clears on entry to LOAD. It does not wrap, because the state exits at TIMEOUT_CYCLES-1.
- Latency: START to first WR_EN=1 is 2 cycles (IDLE→LOAD, LOAD→RUN). ENG_DONE to DONE pulse is DRAIN_CYCLES+1 cycles.
- RESET asserted mid-job: immediate return to reset values. BUF_SEL resets to 0 and no DONE is produced.

Decomposition:
- Shared package coproc_pkg:
  - Algorithm codes ALG_NN/PR/DC/BA.
  - State enum (IDLE, LOAD, RUN, DRAIN, FIN, ERR).
  - ERR_CODE constants.
- One sub-module, job_timer: loadable down/up counter with terminal-count flag, reused for both the timeout and drain counts.
- The rest is a single FSM module.

Test Plan:
- NN job: START with ALGORITHM=0, ENG_DONE driven high 100 cycles after ENG_RESET rises → WR_EN high from cycle 2 through DONE-1; DONE pulses 3 cycles after ENG_DONE (DRAIN=2); BUF_SEL 0→1; BUSY low after the pulse.
- Unsupported algorithm: START with ALGORITHM=2, ALG_MASK=4'b0001 → 1 cycle later ERROR=1, ERR_CODE=1; ENG_RESET never leaves 0; WR_EN never set; BUF_SEL unchanged.
- Timeout: TIMEOUT_CYCLES=50, ENG_DONE held 0 → ERR_CODE=2 at RUN cycle 50; no DONE; ENG_RESET returns to 0.
- Abort race: ABORT and ENG_DONE both high in the same RUN cycle → ERR_CODE=3, no DONE, BUF_SEL unchanged.
- Busy rejection: second START with ALGORITHM=3 mid-RUN → ALG_SEL stays 0 and the job completes normally. A START in the FIN cycle is also ignored.
- Reset mid-DRAIN: RESET low → all outputs return to reset values asynchronously (before the next edge). After RESET rises, a new NN job completes with BUF_SEL 0→1.
